// File: rtl/memory_sdram_arbiter.sv
// memory_sdram_arbiter: two-port front end for a single SDRAM controller.
// A registered grant (IDLE / HOLD_0 / HOLD_1) owns the downstream request
// path, bursts are capped at MAX_BURST accepted transfers, and read acks are
// routed back to the issuing port through a small tag FIFO.
// Optional feature: define ARBITER_ROUND_ROBIN_EN for round-robin contention
// resolution; without it port 0 has fixed priority.
module memory_sdram_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_request_0,
  input  logic        i_request_1,
  input  logic        i_write_0,
  input  logic        i_write_1,
  input  logic [24:0] i_address_0,
  input  logic [24:0] i_address_1,
  input  logic [31:0] i_data_0,
  input  logic [31:0] i_data_1,
  output logic        o_busy_0,
  output logic        o_busy_1,
  output logic        o_ack_0,
  output logic        o_ack_1,
  output logic [31:0] o_data,
  output logic        o_mem_request,
  output logic        o_mem_write,
  output logic [24:0] o_mem_address,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_busy,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data
);

  localparam int         PtrW       = $clog2(TAG_DEPTH);
  localparam logic [7:0] BurstLimit = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_0 = 2'd1,
    HOLD_1 = 2'd2
  } grant_state_e;

  grant_state_e  state_q, state_d;
  logic [7:0]    burstCount_q, burstCount_d;
  logic [7:0]    burstBase, burstNext;
  logic [PtrW:0] wrPtr_q, wrPtr_d;
  logic [PtrW:0] rdPtr_q, rdPtr_d;
  logic          tagMem_q [TAG_DEPTH];
  logic          errorFlag_q, errorFlag_d;

  logic [1:0]    req, wr;
  logic          grantValid, grantPort, contentionWinner;
  logic          selReq, selWrite, accept;
  logic          fifoEmpty, fifoFull, readBlocked;
  logic          tagPush, tagPop, tagHead;

  assign req = {i_request_1, i_request_0};
  assign wr  = {i_write_1, i_write_0};

`ifdef ARBITER_ROUND_ROBIN_EN
  // Round-robin: the pointer names the port that wins the next contention.
  logic rrPtr_q, rrPtr_d;

  assign contentionWinner = rrPtr_q;

  // Every fresh grant hands preference to the other port.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (state_q == IDLE && grantValid) begin
      rrPtr_d = ~grantPort;
    end
  end

  // Pointer register, port 0 preferred out of reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  assign contentionWinner = 1'b0;
`endif

  // Effective grant: the held port, or a same-cycle pre-grant from IDLE.
  // Reset forces no grant so the ports see busy and nothing goes downstream.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = 1'b0;
    if (i_reset_n) begin
      unique case (state_q)
        HOLD_0: begin
          grantValid = 1'b1;
          grantPort  = 1'b0;
        end
        HOLD_1: begin
          grantValid = 1'b1;
          grantPort  = 1'b1;
        end
        default: begin
          if (i_request_0 && i_request_1) begin
            grantValid = 1'b1;
            grantPort  = contentionWinner;
          end else if (i_request_0) begin
            grantValid = 1'b1;
            grantPort  = 1'b0;
          end else if (i_request_1) begin
            grantValid = 1'b1;
            grantPort  = 1'b1;
          end
        end
      endcase
    end
  end

  // Tag FIFO status; a pop in the same cycle frees room for a new read.
  assign fifoEmpty   = (wrPtr_q == rdPtr_q);
  assign fifoFull    = (wrPtr_q[PtrW] != rdPtr_q[PtrW]) &&
                       (wrPtr_q[PtrW-1:0] == rdPtr_q[PtrW-1:0]);
  assign readBlocked = fifoFull & ~i_mem_ack;

  // Downstream mux of the granted port; reads are held back when no tag slot.
  assign selReq        = grantValid & req[grantPort];
  assign selWrite      = wr[grantPort];
  assign o_mem_request = selReq & ~(~selWrite & readBlocked);
  assign o_mem_write   = selWrite;
  assign o_mem_address = grantPort ? i_address_1 : i_address_0;
  assign o_mem_data    = grantPort ? i_data_1 : i_data_0;

  assign o_busy_0 = i_request_0 &
                    (~(grantValid & ~grantPort) | i_mem_busy | (~i_write_0 & readBlocked));
  assign o_busy_1 = i_request_1 &
                    (~(grantValid & grantPort) | i_mem_busy | (~i_write_1 & readBlocked));

  assign accept  = o_mem_request & ~i_mem_busy;
  assign tagPush = accept & ~selWrite;
  assign tagPop  = i_mem_ack & ~fifoEmpty;
  assign tagHead = tagMem_q[rdPtr_q[PtrW-1:0]];

  // Read data is a pure pass-through; the tag at the head picks the ack.
  assign o_ack_0 = tagPop & ~tagHead;
  assign o_ack_1 = tagPop & tagHead;
  assign o_data  = i_mem_data;

  // Grant/burst next state: drop the grant when the owner lets go or its
  // burst budget is spent; a stalled owner keeps the grant.
  always_comb begin
    state_d      = state_q;
    burstCount_d = burstCount_q;
    burstBase    = (state_q == IDLE) ? 8'd0 : burstCount_q;
    burstNext    = burstBase + 8'(accept);
    if (!grantValid) begin
      state_d      = IDLE;
      burstCount_d = 8'd0;
    end else if (state_q != IDLE && !selReq) begin
      state_d      = IDLE;
      burstCount_d = 8'd0;
    end else if (burstNext >= BurstLimit) begin
      state_d      = IDLE;
      burstCount_d = 8'd0;
    end else begin
      state_d      = grantPort ? HOLD_1 : HOLD_0;
      burstCount_d = burstNext;
    end
  end

  // FIFO pointer and sticky spurious-ack flag next state.
  always_comb begin
    wrPtr_d     = wrPtr_q + {{PtrW{1'b0}}, tagPush};
    rdPtr_d     = rdPtr_q + {{PtrW{1'b0}}, tagPop};
    errorFlag_d = errorFlag_q | (i_mem_ack & fifoEmpty);
  end

  // Grant, burst counter, FIFO pointers and error flag registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      burstCount_q <= 8'd0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      errorFlag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burstCount_q <= burstCount_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      errorFlag_q  <= errorFlag_d;
    end
  end

  // Tag storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge i_clk) begin
    if (tagPush) begin
      tagMem_q[wrPtr_q[PtrW-1:0]] <= grantPort;
    end
  end

endmodule

// File: tb/tb_memory_sdram_arbiter.sv
// tb_memory_sdram_arbiter: table-driven vectors, hand sequences for bursts,
// stalls and reset, then random traffic against a queue-based reference model.
module tb_memory_sdram_arbiter;

  localparam int MaxBurst = 8;
  localparam int TagDepth = 4;
`ifdef ARBITER_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif
  localparam logic [24:0] AddrP0 = 25'h0000010;
  localparam logic [24:0] AddrP1 = 25'h0000020;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_request_0, i_request_1, i_write_0, i_write_1;
  logic [24:0] i_address_0, i_address_1;
  logic [31:0] i_data_0, i_data_1;
  logic        o_busy_0, o_busy_1, o_ack_0, o_ack_1;
  logic [31:0] o_data;
  logic        o_mem_request, o_mem_write;
  logic [24:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic        i_mem_busy, i_mem_ack;
  logic [31:0] i_mem_data;

  int vectorsApplied;
  int miscompares;

  // Reference model state: owner (-1 = none), accepted count, preferred port,
  // outstanding read tags in issue order, sticky error.
  int mOwner;
  int mCount;
  int mPrefer;
  bit mTags[$];
  bit mErr;

  typedef struct packed {
    logic        rstN;
    logic        req0;
    logic        req1;
    logic        wr0;
    logic        wr1;
    logic        memBusy;
    logic        memAck;
    logic [24:0] addr0;
    logic [24:0] addr1;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] memData;
  } stim_t;

  typedef struct {
    logic [5:0]  inBits;
    logic [4:0]  expBits;
    logic        chkAddr;
    logic [24:0] addr;
  } vec_t;

  memory_sdram_arbiter #(.MAX_BURST(MaxBurst), .TAG_DEPTH(TagDepth)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_request_0(i_request_0), .i_request_1(i_request_1),
    .i_write_0(i_write_0), .i_write_1(i_write_1),
    .i_address_0(i_address_0), .i_address_1(i_address_1),
    .i_data_0(i_data_0), .i_data_1(i_data_1),
    .o_busy_0(o_busy_0), .o_busy_1(o_busy_1),
    .o_ack_0(o_ack_0), .o_ack_1(o_ack_1), .o_data(o_data),
    .o_mem_request(o_mem_request), .o_mem_write(o_mem_write),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .i_mem_busy(i_mem_busy), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rstN    = 1'b1;
    s.addr0   = AddrP0;
    s.addr1   = AddrP1;
    s.data0   = 32'h1111_0000;
    s.data1   = 32'h2222_0000;
    s.memData = 32'hDEAD_BEEF;
    return s;
  endfunction

  function automatic vec_t mkVec(input logic [10:0] bits, input logic chk, input logic [24:0] a);
    vec_t v;
    v.inBits  = bits[10:5];
    v.expBits = bits[4:0];
    v.chkAddr = chk;
    v.addr    = a;
    return v;
  endfunction

  task automatic modelReset();
    mOwner  = -1;
    mCount  = 0;
    mPrefer = 0;
    mTags.delete();
    mErr    = 1'b0;
  endtask

  function automatic int modelGrant(input stim_t s);
    if (!s.rstN) return -1;
    if (mOwner >= 0) return mOwner;
    if (s.req0 && s.req1) return mPrefer;
    if (s.req0) return 0;
    if (s.req1) return 1;
    return -1;
  endfunction

  function automatic bit modelBusy(input stim_t s, input int port, input int g);
    bit rq, w, blocked;
    rq = (port == 1) ? s.req1 : s.req0;
    w  = (port == 1) ? s.wr1 : s.wr0;
    blocked = (mTags.size() == TagDepth) && !s.memAck;
    return rq && ((g != port) || s.memBusy || (!w && blocked));
  endfunction

  task automatic modelExpect(input stim_t s, output logic [95:0] exp, output logic [95:0] mask);
    int g;
    bit b0, b1, a0, a1, mr, rq, w, ackValid, blocked;
    g = modelGrant(s);
    b0 = modelBusy(s, 0, g);
    b1 = modelBusy(s, 1, g);
    ackValid = s.memAck && (mTags.size() > 0);
    a0 = ackValid && (mTags[0] == 1'b0);
    a1 = ackValid && (mTags[0] == 1'b1);
    rq = (g == 1) ? s.req1 : s.req0;
    w  = (g == 1) ? s.wr1 : s.wr0;
    blocked = (mTags.size() == TagDepth) && !s.memAck;
    mr = (g >= 0) && rq && !(!w && blocked);
    exp  = {b0, b1, a0, a1, mr, mErr, w, (g == 1) ? s.addr1 : s.addr0,
            (g == 1) ? s.data1 : s.data0, s.memData};
    mask = {6'h3f, (g >= 0) ? {58{1'b1}} : 58'd0, {32{1'b1}}};
  endtask

  task automatic modelUpdate(input stim_t s);
    int g;
    bit rq, w, acc;
    if (!s.rstN) return;
    g   = modelGrant(s);
    rq  = (g == 1) ? s.req1 : s.req0;
    w   = (g == 1) ? s.wr1 : s.wr0;
    acc = (g >= 0) && rq && !modelBusy(s, g, g);
    if (s.memAck) begin
      if (mTags.size() > 0) void'(mTags.pop_front());
      else mErr = 1'b1;
    end
    if (acc && !w) mTags.push_back(g[0]);
    if (g < 0) begin
      mOwner = -1;
      mCount = 0;
    end else begin
      if (mOwner < 0) begin
        mCount = 0;
        if (RoundRobin) mPrefer = 1 - g;
      end
      if (mOwner >= 0 && !rq) begin
        mOwner = -1;
        mCount = 0;
      end else begin
        mCount += int'(acc);
        if (mCount >= MaxBurst) begin
          mOwner = -1;
          mCount = 0;
        end else begin
          mOwner = g;
        end
      end
    end
  endtask

  function automatic logic [95:0] actualOut();
    return {o_busy_0, o_busy_1, o_ack_0, o_ack_1, o_mem_request, dut.errorFlag_q,
            o_mem_write, o_mem_address, o_mem_data, o_data};
  endfunction

  function automatic int dutAcceptPort();
    if (i_request_0 && !o_busy_0) return 0;
    if (i_request_1 && !o_busy_1) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act,
                             input logic [95:0] exp, input logic [95:0] mask);
    vectorsApplied++;
    if (((act ^ exp) & mask) !== 96'd0) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act & mask, exp & mask);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    i_reset_n   = s.rstN;
    i_request_0 = s.req0;
    i_request_1 = s.req1;
    i_write_0   = s.wr0;
    i_write_1   = s.wr1;
    i_mem_busy  = s.memBusy;
    i_mem_ack   = s.memAck;
    i_address_0 = s.addr0;
    i_address_1 = s.addr1;
    i_data_0    = s.data0;
    i_data_1    = s.data1;
    i_mem_data  = s.memData;
  endtask

  // One cycle: drive at the falling edge, compare against the model shortly
  // after, then advance the model to the state after the next rising edge.
  task automatic applyStimulus(input stim_t s, input string name);
    logic [95:0] exp, mask;
    @(negedge i_clk);
    driveInputs(s);
    if (!s.rstN) modelReset();
    #1;
    modelExpect(s, exp, mask);
    checkOutput(name, actualOut(), exp, mask);
    modelUpdate(s);
  endtask

  task automatic resetCycle();
    stim_t s;
    s = idleStim();
    s.rstN = 1'b0;
    applyStimulus(s, "resetCycle");
  endtask

  vec_t vecs[27];

  initial begin
    stim_t s;
    vectorsApplied = 0;
    miscompares    = 0;
    modelReset();

    // Table rows: {req0 req1 wr0 wr1 memBusy memAck} _ {busy0 busy1 ack0 ack1 memReq}
    vecs[0]  = mkVec(11'b000000_00000, 1'b0, 25'd0);
    vecs[1]  = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[2]  = mkVec(11'b000000_00000, 1'b0, 25'd0);
    vecs[3]  = mkVec(11'b000000_00000, 1'b0, 25'd0);
    vecs[4]  = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[5]  = mkVec(11'b000000_00000, 1'b0, 25'd0);
    vecs[6]  = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[7]  = mkVec(11'b010000_01000, 1'b0, 25'd0);
    vecs[8]  = mkVec(11'b010000_00001, 1'b1, AddrP1);
    vecs[9]  = mkVec(11'b100000_10000, 1'b0, 25'd0);
    vecs[10] = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[11] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[12] = mkVec(11'b000001_00010, 1'b0, 25'd0);
    vecs[13] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[14] = mkVec(11'b000001_00000, 1'b0, 25'd0);
    vecs[15] = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[16] = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[17] = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[18] = mkVec(11'b100000_00001, 1'b1, AddrP0);
    vecs[19] = mkVec(11'b100000_10000, 1'b0, 25'd0);
    vecs[20] = mkVec(11'b100001_00101, 1'b1, AddrP0);
    vecs[21] = mkVec(11'b000000_00000, 1'b0, 25'd0);
    vecs[22] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[23] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[24] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[25] = mkVec(11'b000001_00100, 1'b0, 25'd0);
    vecs[26] = mkVec(11'b000001_00000, 1'b0, 25'd0);

    // Power-on reset with requests and a stray ack present.
    s = idleStim();
    s.rstN = 1'b0;
    driveInputs(s);
    repeat (2) @(posedge i_clk);
    s.req0 = 1'b1;
    s.req1 = 1'b1;
    s.memAck = 1'b1;
    applyStimulus(s, "resetModel");
    checkOutput("resetOutputs",
                96'({o_busy_0, o_busy_1, o_ack_0, o_ack_1, o_mem_request, dut.errorFlag_q}),
                96'(6'b110000), '1);

    // Directed table: single read/ack, interleaved reads, spurious ack, full FIFO.
    resetCycle();
    for (int i = 0; i < 27; i++) begin
      s = idleStim();
      {s.req0, s.req1, s.wr0, s.wr1, s.memBusy, s.memAck} = vecs[i].inBits;
      applyStimulus(s, $sformatf("tableModel[%0d]", i));
      checkOutput($sformatf("table[%0d]", i),
                  96'({o_busy_0, o_busy_1, o_ack_0, o_ack_1, o_mem_request, o_data}),
                  96'({vecs[i].expBits, 32'hDEAD_BEEF}), '1);
      if (vecs[i].chkAddr) begin
        checkOutput($sformatf("tableAddr[%0d]", i), 96'({o_mem_write, o_mem_address}),
                    96'({1'b0, vecs[i].addr}), '1);
      end
      if (i == 14) begin
        checkOutput("spuriousNoAck", 96'({o_ack_0, o_ack_1}), 96'(2'b00), '1);
      end
    end
    checkOutput("errFlagSticky", 96'(dut.errorFlag_q), 96'(1'b1), '1);

    // Continuous writes from both ports: bursts of MAX_BURST per port.
    resetCycle();
    for (int i = 0; i < 4 * MaxBurst; i++) begin
      s = idleStim();
      s.req0 = 1'b1;
      s.req1 = 1'b1;
      s.wr0  = 1'b1;
      s.wr1  = 1'b1;
      applyStimulus(s, "burstModel");
      checkOutput($sformatf("burstAccept[%0d]", i), 96'(dutAcceptPort()),
                  96'(RoundRobin ? ((i / MaxBurst) % 2) : 0), '1);
    end

    // Port 1 write burst stalled by the controller for five cycles.
    resetCycle();
    begin : stallSeq
      logic [13:0] req0Pat;
      logic [13:0] busyPat;
      int          expAcc[14];
      req0Pat = 14'b11_1111_1111_1110;
      busyPat = 14'b00_0000_1111_1000;
      expAcc  = '{1, 1, 1, -1, -1, -1, -1, -1, 1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 14; i++) begin
        s = idleStim();
        s.req0    = req0Pat[i];
        s.req1    = 1'b1;
        s.wr0     = 1'b1;
        s.wr1     = 1'b1;
        s.memBusy = busyPat[i];
        applyStimulus(s, "stallModel");
        checkOutput($sformatf("stallAccept[%0d]", i), 96'(dutAcceptPort()), 96'(expAcc[i]), '1);
        if (busyPat[i]) begin
          checkOutput($sformatf("stallHold[%0d]", i), 96'({o_busy_1, o_mem_address}),
                      96'({1'b1, AddrP1}), '1);
        end
      end
    end

    // Reset with two reads outstanding discards their tags.
    resetCycle();
    s = idleStim();
    s.req0 = 1'b1;
    applyStimulus(s, "pendRead0");
    s = idleStim();
    s.req1 = 1'b1;
    applyStimulus(s, "pendWait");
    applyStimulus(s, "pendRead1");
    s = idleStim();
    s.rstN   = 1'b0;
    s.req1   = 1'b1;
    s.memAck = 1'b1;
    applyStimulus(s, "midResetModel");
    checkOutput("midReset", 96'({o_ack_0, o_ack_1, o_busy_1, o_mem_request}),
                96'(4'b0010), '1);
    s = idleStim();
    s.memAck = 1'b1;
    applyStimulus(s, "postResetAck");
    checkOutput("postResetNoAck", 96'({o_ack_0, o_ack_1}), 96'(2'b00), '1);
    s = idleStim();
    s.req1 = 1'b1;
    applyStimulus(s, "postResetGrant");
    checkOutput("postResetIdle", 96'({o_busy_1, o_mem_request, dut.errorFlag_q}),
                96'(3'b011), '1);

    // Random traffic against the reference model.
    resetCycle();
    for (int i = 0; i < 600; i++) begin
      s = idleStim();
      s.rstN    = ($urandom_range(0, 149) != 0);
      s.req0    = ($urandom_range(0, 9) < 7);
      s.req1    = ($urandom_range(0, 9) < 7);
      s.wr0     = $urandom_range(0, 1) == 1;
      s.wr1     = $urandom_range(0, 1) == 1;
      s.memBusy = ($urandom_range(0, 9) < 2);
      s.memAck  = ($urandom_range(0, 9) < 4);
      s.addr0   = 25'($urandom);
      s.addr1   = 25'($urandom);
      s.data0   = $urandom;
      s.data1   = $urandom;
      s.memData = $urandom;
      applyStimulus(s, $sformatf("random[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
